// File: rtl/rf_pkg.sv
// Shared constants, command opcodes and controller state encoding for rf_access_ctrl.
package rf_pkg;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int WR_LIMIT = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_PAIR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_PAIR,
    S_PAIR2,
    S_DUMP,
    S_DUMP_WAIT,
    S_RSP_WAIT
  } state_e;

endpackage

// File: rtl/rf_rsp_slot.sv
// One-entry response holding register; contents stay frozen while valid && !ready.
module rf_rsp_slot
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              err,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      err   <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
      err   <= load_err;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Command-driven initiator for the 8x10 register file (READ/WRITE/PAIR/DUMP).
// Optional write protection of addresses >= WR_LIMIT is enabled by defining RF_WPROT_EN.
module rf_access_ctrl
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state, state_n;
  logic              cmd_ready_n, busy_n;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n, raddr1_n, raddr2_n;
  logic [DATA_W-1:0] wdata_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W-1:0] hold_addr, hold_addr_n;
  logic [DATA_W-1:0] hold_data, hold_data_n;
  logic              wr_err, wr_err_n;
  logic              prot;
  logic              hs;

  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              load_last;

`ifdef RF_WPROT_EN
  assign prot = (cmd_addr >= ADDR_W'(WR_LIMIT));
`else
  assign prot = 1'b0;
`endif

  assign hs = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      idx       <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      wr_err    <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      busy      <= busy_n;
      rf_we     <= we_n;
      rf_waddr  <= waddr_n;
      rf_wdata  <= wdata_n;
      rf_raddr1 <= raddr1_n;
      rf_raddr2 <= raddr2_n;
      idx       <= idx_n;
      hold_addr <= hold_addr_n;
      hold_data <= hold_data_n;
      wr_err    <= wr_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    we_n        = 1'b0;
    waddr_n     = rf_waddr;
    wdata_n     = rf_wdata;
    raddr1_n    = rf_raddr1;
    raddr2_n    = rf_raddr2;
    idx_n       = idx;
    hold_addr_n = hold_addr;
    hold_data_n = hold_data;
    wr_err_n    = wr_err;
    load        = 1'b0;
    load_addr   = rf_raddr1;
    load_data   = rf_rdata1;
    load_err    = 1'b0;
    load_last   = 1'b1;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (op_e'(cmd_op))
            OP_WRITE: begin
              state_n  = S_WR;
              we_n     = !prot;
              waddr_n  = cmd_addr;
              wdata_n  = cmd_wdata;
              wr_err_n = prot;
            end
            OP_READ: begin
              state_n  = S_RD;
              raddr1_n = cmd_addr;
            end
            OP_PAIR: begin
              state_n  = S_PAIR;
              raddr1_n = cmd_addr;
              raddr2_n = cmd_addr + ADDR_W'(1);
            end
            default: begin
              state_n  = S_DUMP;
              raddr1_n = '0;
              idx_n    = '0;
            end
          endcase
        end
      end
      // File has taken the write at this edge; respond alongside it
      S_WR: begin
        load      = 1'b1;
        load_addr = rf_waddr;
        load_data = rf_wdata;
        load_err  = wr_err;
        state_n   = S_RSP_WAIT;
      end
      S_RD: begin
        load    = 1'b1;
        state_n = S_RSP_WAIT;
      end
      S_PAIR: begin
        load        = 1'b1;
        load_last   = 1'b0;
        hold_addr_n = rf_raddr2;
        hold_data_n = rf_rdata2;
        state_n     = S_PAIR2;
      end
      S_PAIR2: begin
        if (hs) begin
          load      = 1'b1;
          load_addr = hold_addr;
          load_data = hold_data;
          state_n   = S_RSP_WAIT;
        end
      end
      S_DUMP: begin
        load      = 1'b1;
        load_last = (idx == LAST_IDX);
        state_n   = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            state_n = S_IDLE;
          end else begin
            idx_n    = idx + ADDR_W'(1);
            raddr1_n = idx + ADDR_W'(1);
            state_n  = S_DUMP;
          end
        end
      end
      S_RSP_WAIT: begin
        if (hs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    busy_n      = (state_n != S_IDLE);
    cmd_ready_n = (state_n == S_IDLE) && !(load || (rsp_valid && !rsp_ready));
  end

  rf_rsp_slot u_rsp_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_err  (load_err),
    .load_last (load_last),
    .ready     (rsp_ready),
    .valid     (rsp_valid),
    .addr      (rsp_addr),
    .data      (rsp_data),
    .err       (rsp_err),
    .last      (rsp_last)
  );

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl driving a behavioural 8x10 register file (addresses >= 4 read-only).
module tb_rf_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [9:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_addr;
  logic [9:0] rsp_data;
  logic       rsp_err;
  logic       rsp_last;
  logic       busy;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [9:0] rf_wdata;
  logic [2:0] rf_raddr1;
  logic [2:0] rf_raddr2;
  logic [9:0] rf_rdata1;
  logic [9:0] rf_rdata2;

  logic       mem_clr;
  logic [9:0] mem [8];
  int         we_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rf_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2)
  );

  // Register file target: combinational reads, write at edge, top half read-only
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (rf_we && rf_waddr < 3'd4) begin
      mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata1 = mem[rf_raddr1];
  assign rf_rdata2 = mem[rf_raddr2];

  always @(negedge clk) if (rf_we === 1'b1) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] a, input logic [9:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic get_rsp(input string tag, input logic [2:0] a, input logic [9:0] d,
                         input logic l, input logic e);
    wait_valid(tag);
    chk(tag, {17'd0, rsp_addr, rsp_data, rsp_last, rsp_err}, {17'd0, a, d, l, e});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_PAIR  = 2'b11;

  initial begin
    logic [9:0] exp_dump [8];
    logic       prot_en;
    int         w0;
    logic [2:0] s_addr;
    logic [9:0] s_data;
    logic       s_last;
    logic       r;
    bit         done;
    int         guard;

`ifdef RF_WPROT_EN
    prot_en = 1'b1;
`else
    prot_en = 1'b0;
`endif
    exp_dump[0] = 10'd7;   exp_dump[1] = 10'd55; exp_dump[2] = 10'd0; exp_dump[3] = 10'd200;
    exp_dump[4] = 10'd0;   exp_dump[5] = 10'd0;  exp_dump[6] = 10'd0; exp_dump[7] = 10'd0;

    rst = 1'b1; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;

    // 1: reset state, then DUMP of cleared file
    repeat (2) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    send_cmd(OP_DUMP, 3'd5, 10'd0);
    for (int i = 0; i < 8; i++) get_rsp("dump0", 3'(i), 10'd0, (i == 7), 1'b0);

    // 2: write then read back
    w0 = we_cnt;
    send_cmd(OP_WRITE, 3'd1, 10'd55);
    get_rsp("wr1", 3'd1, 10'd55, 1'b1, 1'b0);
    chk("wr1_we_cycles", 32'(we_cnt - w0), 32'd1);
    send_cmd(OP_READ, 3'd1, 10'd0);
    get_rsp("rd1", 3'd1, 10'd55, 1'b1, 1'b0);

    // 3: write to a non-writeable address
    w0 = we_cnt;
    send_cmd(OP_WRITE, 3'd4, 10'd100);
    get_rsp("wr4", 3'd4, 10'd100, 1'b1, prot_en);
    chk("wr4_we_cycles", 32'(we_cnt - w0), prot_en ? 32'd0 : 32'd1);
    send_cmd(OP_READ, 3'd4, 10'd0);
    get_rsp("rd4", 3'd4, 10'd0, 1'b1, 1'b0);

    // 4: PAIR reads, including address wrap
    send_cmd(OP_WRITE, 3'd3, 10'd200);
    get_rsp("wr3", 3'd3, 10'd200, 1'b1, 1'b0);
    send_cmd(OP_WRITE, 3'd0, 10'd7);
    get_rsp("wr0", 3'd0, 10'd7, 1'b1, 1'b0);
    send_cmd(OP_PAIR, 3'd3, 10'd0);
    get_rsp("pair3_a", 3'd3, 10'd200, 1'b0, 1'b0);
    get_rsp("pair3_b", 3'd4, 10'd0, 1'b1, 1'b0);
    send_cmd(OP_PAIR, 3'd7, 10'd0);
    get_rsp("pair7_a", 3'd7, 10'd0, 1'b0, 1'b0);
    get_rsp("pair7_b", 3'd0, 10'd7, 1'b1, 1'b0);
    chk("pair_raddr2_hold", {29'd0, rf_raddr2}, 32'd0);

    // 5: DUMP under random back-pressure
    send_cmd(OP_DUMP, 3'd2, 10'd0);
    for (int i = 0; i < 8; i++) begin
      wait_valid("dump_bp");
      chk("dump_bp", {17'd0, rsp_addr, rsp_data, rsp_last, rsp_err},
          {17'd0, 3'(i), exp_dump[i], (i == 7), 1'b0});
      s_addr = rsp_addr; s_data = rsp_data; s_last = rsp_last;
      done = 1'b0;
      guard = 0;
      while (!done && guard < 20) begin
        r = (guard >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_ready = r;
        @(negedge clk);
        rsp_ready = 1'b0;
        guard++;
        if (r) begin
          done = 1'b1;
          chk("dump_bp_nodup", {31'd0, rsp_valid}, 32'd0);
        end else begin
          chk("dump_bp_stall", {17'd0, rsp_valid, rsp_addr, rsp_data, rsp_last},
              {17'd0, 1'b1, s_addr, s_data, s_last});
        end
      end
    end
    chk("dump_bp_idle", {30'd0, cmd_ready, busy}, {30'd0, 1'b1, 1'b0});

    // 6: reset in the middle of a DUMP
    send_cmd(OP_DUMP, 3'd0, 10'd0);
    for (int i = 0; i < 3; i++) get_rsp("dump_rst_pre", 3'(i), exp_dump[i], 1'b0, 1'b0);
    wait_valid("dump_rst_idx3");
    chk("dump_rst_idx3", {29'd0, rsp_addr}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", {29'd0, rsp_valid, busy, cmd_ready}, {29'd0, 1'b0, 1'b0, 1'b1});
    send_cmd(OP_DUMP, 3'd6, 10'd0);
    for (int i = 0; i < 8; i++) get_rsp("dump_after_rst", 3'(i), exp_dump[i], (i == 7), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
